rpn_stack_ctrl: RTL and testbench



---
 rtl/rpn_stack_ctrl_pkg.sv | 20 ++
 rtl/rpn_stack_ctrl_stack_ram.sv | 27 ++
 rtl/rpn_stack_ctrl.sv | 151 +++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_stack_ctrl_pkg.sv
// Shared definitions for the RPN calculator operand stack: default sizes,
// controller state encoding and the RAM address-width helper.
package rpn_stack_ctrl_pkg;

    localparam int CALC_WIDTH  = 32;
    localparam int CALC_DEPTH  = 512;
    localparam int CALC_SIZE_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP_RD = 2'd1,
        ST_POP_LD = 2'd2
    } state_t;

    // Holds DEPTH-1 words; never narrower than one bit even for tiny stacks.
    function automatic int ram_addr_w(input int depth);
        return (depth - 1 > 1) ? $clog2(depth - 1) : 1;
    endfunction

endpackage

// File: rtl/rpn_stack_ctrl_stack_ram.sv
// Single-port synchronous RAM holding the stack elements below the top register.
// Read data is registered: one cycle latency, no reset, no backpressure.
module stack_ram #(
    parameter int WIDTH = 32,
    parameter int WORDS = 511,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [WORDS];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Operand stack responder: top element in a register, the rest in stack_ram.
// push/replace/short pop finish in one edge; a deep pop drops out_vld for 2 cycles.
module rpn_stack_ctrl
    import rpn_stack_ctrl_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DEPTH  = CALC_DEPTH,
    parameter int SIZE_W = CALC_SIZE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              replace,
    input  logic              clear,
    input  logic [WIDTH-1:0]  in_num,
    output logic [WIDTH-1:0]  top,
    output logic [SIZE_W-1:0] size,
    output logic              error,
    output logic              out_vld
);

    localparam int                AW      = ram_addr_w(DEPTH);
    localparam logic [SIZE_W-1:0] DEPTH_S = SIZE_W'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_top;
    logic [SIZE_W-1:0]   r_size;
    logic                r_error;
    logic [AW-1:0]       r_rd_addr;

    logic                w_out_vld;
    logic                w_any_cmd;
    logic                w_multi;
    logic                w_empty;
    logic                w_full;
    logic                w_illegal;
    logic                w_accept;
    logic                w_do_push;
    logic                w_do_pop;
    logic                w_do_replace;
    logic                w_pop_last;
    logic                w_ram_we;
    logic [AW-1:0]       w_ram_addr;
    logic [AW-1:0]       w_wr_addr;
    logic [AW-1:0]       w_pop_addr;
    logic [WIDTH-1:0]    w_ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_out_vld    = (r_state == ST_IDLE);
        w_any_cmd    = push | pop | replace;
        w_multi      = (push & pop) | (push & replace) | (pop & replace);
        w_empty      = (r_size == '0);
        w_full       = (r_size == DEPTH_S);
        // Any command seen while busy is an error, even if it would be legal in IDLE.
        w_illegal    = w_any_cmd & (~w_out_vld | w_multi | (push & w_full) |
                                    ((pop | replace) & w_empty));
        w_accept     = w_any_cmd & ~w_illegal & ~clear;
        w_do_push    = w_accept & push;
        w_do_pop     = w_accept & pop;
        w_do_replace = w_accept & replace;
        w_pop_last   = w_do_pop & (r_size == SIZE_W'(1));
        w_wr_addr    = AW'(r_size - SIZE_W'(1));
        w_pop_addr   = AW'(r_size - SIZE_W'(2));
        w_ram_we     = w_do_push & ~w_empty;
        w_ram_addr   = w_ram_we ? w_wr_addr : r_rd_addr;

        unique case (r_state)
            ST_IDLE: begin
                if (w_do_pop && !w_pop_last) begin
                    w_state_nxt = ST_POP_RD;
                end
            end
            ST_POP_RD: w_state_nxt = ST_POP_LD;
            ST_POP_LD: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        if (clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top     <= '0;
            r_size    <= '0;
            r_error   <= 1'b0;
            r_rd_addr <= '0;
        end else if (clear) begin
            r_top   <= '0;
            r_size  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_illegal) begin
                r_error <= 1'b1;
            end else if (w_accept) begin
                r_error <= 1'b0;
            end

            if (w_do_push) begin
                r_top  <= in_num;
                r_size <= r_size + SIZE_W'(1);
            end

            if (w_do_replace) begin
                r_top <= in_num;
            end

            if (w_pop_last) begin
                r_top  <= '0;
                r_size <= '0;
            end else if (w_do_pop) begin
                r_size    <= r_size - SIZE_W'(1);
                r_rd_addr <= w_pop_addr;
            end

            if (r_state == ST_POP_LD) begin
                r_top <= w_ram_rdata;
            end
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .WORDS (DEPTH - 1),
        .AW    (AW)
    ) u_stack_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_top),
        .rdata (w_ram_rdata)
    );

    assign top     = r_top;
    assign size    = r_size;
    assign error   = r_error;
    assign out_vld = w_out_vld;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scenario bench for rpn_stack_ctrl (DEPTH=4) with a reference stack model and scoreboard queue.
module tb_rpn_stack_ctrl;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int SIZE_W = 10;

    typedef struct packed {
        logic [WIDTH-1:0]  top;
        logic [SIZE_W-1:0] size;
        logic              err;
        logic              vld;
    } obs_t;

    logic              clk;
    logic              reset_n;
    logic              push;
    logic              pop;
    logic              replace;
    logic              clear;
    logic [WIDTH-1:0]  in_num;
    logic [WIDTH-1:0]  top;
    logic [SIZE_W-1:0] size;
    logic              error;
    logic              out_vld;

    obs_t              sb_q[$];
    logic [WIDTH-1:0]  model[$];
    logic              m_err;
    int                checks;
    int                errors;

    rpn_stack_ctrl #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .SIZE_W (SIZE_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .replace (replace),
        .clear   (clear),
        .in_num  (in_num),
        .top     (top),
        .size    (size),
        .error   (error),
        .out_vld (out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs_now();
        obs_t o;
        o.top  = top;
        o.size = size;
        o.err  = error;
        o.vld  = out_vld;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.top  = (model.size() > 0) ? model[model.size()-1] : '0;
        o.size = SIZE_W'(model.size());
        o.err  = m_err;
        o.vld  = 1'b1;
        return o;
    endfunction

    // Drives one command for a single edge, updates the model and queues the expected result.
    task automatic drive(input logic p, input logic po, input logic r, input logic c,
                         input logic [WIDTH-1:0] num, input bit busy);
        int n;
        push = p; pop = po; replace = r; clear = c; in_num = num;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; replace = 1'b0; clear = 1'b0;
        n = int'(p) + int'(po) + int'(r);
        if (c) begin
            model.delete();
            m_err = 1'b0;
        end else if (n == 0) begin
            m_err = m_err;
        end else if (busy || n > 1 || (p && model.size() == DEPTH) ||
                     ((po || r) && model.size() == 0)) begin
            m_err = 1'b1;
        end else begin
            m_err = 1'b0;
            if (p) model.push_back(num);
            else if (r) model[model.size()-1] = num;
            else void'(model.pop_back());
        end
        sb_q.push_back(model_obs());
    endtask

    task automatic wait_idle(output int low_cycles);
        low_cycles = 0;
        while (!out_vld && low_cycles < 20) begin
            @(posedge clk);
            #1;
            low_cycles++;
        end
        if (!out_vld) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: out_vld=%b after %0d cycles", out_vld, low_cycles);
        end
    endtask

    task automatic test_reset();
        obs_t exp;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp = '{top: '0, size: '0, err: 1'b0, vld: 1'b1};
        checks++;
        if (obs_now() !== exp) begin
            errors++;
            $display("FAIL reset got %h want %h", obs_now(), exp);
        end
    endtask

    task automatic test_push_pop();
        obs_t exp;
        int   lc;
        drive(1, 0, 0, 0, 32'd5, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL push5 got %h want %h", obs_now(), exp); end
        drive(1, 0, 0, 0, 32'd7, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp || lc !== 0) begin
            errors++; $display("FAIL push7 got %h lowcyc %0d want %h lowcyc 0", obs_now(), lc, exp);
        end
        drive(0, 1, 0, 0, 32'd0, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (lc !== 2) begin errors++; $display("FAIL pop_lowcyc got %0d want 2", lc); end
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL pop_deep got %h want %h", obs_now(), exp); end
        drive(0, 1, 0, 0, 32'd0, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp || lc !== 0) begin
            errors++; $display("FAIL pop_last got %h lowcyc %0d want %h lowcyc 0", obs_now(), lc, exp);
        end
    endtask

    task automatic test_errors();
        obs_t exp;
        int   lc;
        drive(0, 1, 0, 0, 32'd0, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL pop_empty got %h want %h", obs_now(), exp); end
        drive(0, 0, 1, 0, 32'd11, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL repl_empty got %h want %h", obs_now(), exp); end
        drive(1, 0, 0, 0, 32'd3, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL push_clrerr got %h want %h", obs_now(), exp); end
    endtask

    task automatic test_full();
        obs_t exp;
        int   lc;
        drive(0, 0, 0, 1, 32'd0, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL clear got %h want %h", obs_now(), exp); end
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 0, WIDTH'(i), 0);
            wait_idle(lc);
            exp = sb_q.pop_front();
        end
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL fill got %h want %h", obs_now(), exp); end
        drive(1, 0, 0, 0, 32'd9, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL push_full got %h want %h", obs_now(), exp); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 32'd0, 0);
            wait_idle(lc);
            exp = sb_q.pop_front();
            checks++;
            if (obs_now() !== exp || lc !== 2) begin
                errors++;
                $display("FAIL drain%0d got %h lowcyc %0d want %h lowcyc 2", i, obs_now(), lc, exp);
            end
        end
    endtask

    task automatic test_replace();
        obs_t exp;
        int   lc;
        drive(0, 0, 0, 1, 32'd0, 0);
        wait_idle(lc);
        void'(sb_q.pop_front());
        drive(1, 0, 0, 0, 32'h1234_5678, 0);
        wait_idle(lc);
        void'(sb_q.pop_front());
        drive(0, 0, 1, 0, 32'hDEAD_BEEF, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL replace got %h want %h", obs_now(), exp); end
        drive(1, 1, 0, 0, 32'h5555_AAAA, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL push_pop got %h want %h", obs_now(), exp); end
    endtask

    task automatic test_clear_in_pop();
        obs_t exp;
        int   lc;
        drive(0, 0, 0, 1, 32'd0, 0);
        wait_idle(lc);
        void'(sb_q.pop_front());
        drive(1, 0, 0, 0, 32'd1, 0);
        drive(1, 0, 0, 0, 32'd2, 0);
        drive(0, 1, 0, 0, 32'd0, 0);
        drive(0, 0, 0, 1, 32'd0, 0);
        repeat (3) void'(sb_q.pop_front());
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL clear_in_pop got %h want %h", obs_now(), exp); end
        drive(1, 0, 0, 0, 32'd1, 0);
        drive(1, 0, 0, 0, 32'd2, 0);
        drive(0, 1, 0, 0, 32'd0, 0);
        drive(1, 0, 0, 0, 32'd9, 1);
        wait_idle(lc);
        repeat (3) void'(sb_q.pop_front());
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp || lc !== 1) begin
            errors++; $display("FAIL push_busy got %h lowcyc %0d want %h lowcyc 1", obs_now(), lc, exp);
        end
    endtask

    task automatic test_reset_mid_pop();
        obs_t exp;
        int   lc;
        drive(0, 0, 0, 1, 32'd0, 0);
        drive(1, 0, 0, 0, 32'hA1, 0);
        drive(1, 0, 0, 0, 32'hB2, 0);
        drive(0, 1, 0, 0, 32'd0, 0);
        repeat (4) void'(sb_q.pop_front());
        #2 reset_n = 1'b0;
        #1;
        exp = '{top: '0, size: '0, err: 1'b0, vld: 1'b1};
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL reset_mid_pop got %h want %h", obs_now(), exp); end
        #3 reset_n = 1'b1;
        model.delete();
        m_err = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 32'h77, 0);
        wait_idle(lc);
        exp = sb_q.pop_front();
        checks++;
        if (obs_now() !== exp) begin errors++; $display("FAIL post_reset_push got %h want %h", obs_now(), exp); end
    endtask

    task automatic test_back_to_back();
        obs_t exp;
        int   lc;
        int   op;
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 2);
            drive(op == 0, op == 1, op == 2, 0, $urandom, 0);
            wait_idle(lc);
            exp = sb_q.pop_front();
            checks++;
            if (obs_now() !== exp) begin
                errors++; $display("FAIL random%0d op %0d got %h want %h", i, op, obs_now(), exp);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_err   = 1'b0;
        reset_n = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        replace = 1'b0;
        clear   = 1'b0;
        in_num  = '0;
        test_reset();
        test_push_pop();
        test_errors();
        test_full();
        test_replace();
        test_clear_in_pop();
        test_reset_mid_pop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
